truth_table_sweeper: RTL

Sequencer that characterises a 3-input combinational gate circuit (one of the team's truth-table logic modules, e.g. the 0x8D function) by driving all eight input combinations in order. It waits a configurable settle time per row, samples the circuit output twice, and assembles the observed 8-bit truth table. It then compares that table against an expected code and reports pass/fail with per-row mismatch and instability flags. It sits between a test/config host and the gate under test, owning the gate's `in1`/`in2`/`in3` drive.

---
 rtl/truth_table_sweeper.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives all eight input rows of a 3-input gate under test, holds each row
//   for SETTLE cycles, samples the gate output twice per row and assembles the
//   observed truth table. At the end of a sweep the table is compared against
//   the expected code captured at start.
//
//   Row r = {in1,in2,in3} maps to table bit (7-r).
//
// Ports
//   clk_i         sole clock, rising edge
//   reset_i       synchronous, active-high reset
//   start_i       request a sweep
//   abort_i       cancel a running sweep (priority over start)
//   expected_i    expected truth-table code, captured on accepted start
//   gate_out_i    output of the gate under test
//   in1_o..in3_o  registered drive to the gate (in1 = MSB of row index)
//   busy_o        sweep in progress
//   done_o        one-cycle completion pulse
//   pass_o        table matches expected and no row was unstable
//   table_o       observed truth table
//   mismatch_o    table XOR expected, per row
//   unstable_o    per-row disagreement between the two samples
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | drive 000, wait for start
// S_RUN    | hold current row, sample twice, advance row
// S_FINISH | one-cycle done pulse; results already registered
module truth_table_sweeper #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [7:0] expected_i,
   input  logic       gate_out_i,
   output logic       in1_o,
   output logic       in2_o,
   output logic       in3_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [7:0] table_o,
   output logic [7:0] mismatch_o,
   output logic [7:0] unstable_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [7:0] CNT_S0  = 8'(SETTLE - 2);
   localparam logic [7:0] CNT_FIN = 8'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] row_q, row_d;
   logic [7:0] cnt_q, cnt_d;
   logic       s0_q, s0_d;
   logic [7:0] exp_q, exp_d;
   logic [2:0] drive_q, drive_d;
   logic [7:0] table_q, table_d;
   logic [7:0] unstable_q, unstable_d;
   logic [7:0] mismatch_q, mismatch_d;
   logic       pass_q, pass_d;
   logic       launch;
   logic [2:0] bit_idx;

   assign bit_idx = 3'd7 - row_q;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      s0_d       = s0_q;
      exp_d      = exp_q;
      drive_d    = drive_q;
      table_d    = table_q;
      unstable_d = unstable_q;
      mismatch_d = mismatch_q;
      pass_d     = pass_q;
      launch     = 1'b0;

      case (state_q)
         S_IDLE: begin
            drive_d = 3'd0;
            if (start_i && !abort_i) launch = 1'b1;
         end

         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
               drive_d = 3'd0;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == CNT_S0) s0_d = gate_out_i;
               if (cnt_q == CNT_FIN) begin
                  table_d[bit_idx]    = gate_out_i;
                  unstable_d[bit_idx] = s0_q ^ gate_out_i;
                  cnt_d               = 8'd0;
                  if (row_q == 3'd7) begin
                     // Results are registered on entry to FINISH so they are
                     // valid in the same cycle as the done pulse.
                     state_d    = S_FINISH;
                     drive_d    = 3'd0;
                     mismatch_d = table_d ^ exp_q;
                     pass_d     = (mismatch_d == 8'd0) && (unstable_d == 8'd0);
                  end else begin
                     row_d   = row_q + 3'd1;
                     drive_d = row_q + 3'd1;
                  end
               end
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
            drive_d = 3'd0;
            // A start seen while leaving FINISH begins the next sweep directly,
            // giving back-to-back sweeps 8*SETTLE+1 cycles apart.
            if (start_i && !abort_i) launch = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
            drive_d = 3'd0;
         end
      endcase

      if (launch) begin
         state_d    = S_RUN;
         exp_d      = expected_i;
         table_d    = 8'd0;
         unstable_d = 8'd0;
         row_d      = 3'd0;
         cnt_d      = 8'd0;
         drive_d    = 3'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         row_q      <= 3'd0;
         cnt_q      <= 8'd0;
         s0_q       <= 1'b0;
         exp_q      <= 8'd0;
         drive_q    <= 3'd0;
         table_q    <= 8'd0;
         unstable_q <= 8'd0;
         mismatch_q <= 8'd0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         s0_q       <= s0_d;
         exp_q      <= exp_d;
         drive_q    <= drive_d;
         table_q    <= table_d;
         unstable_q <= unstable_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
      end
   end

   assign in1_o      = drive_q[2];
   assign in2_o      = drive_q[1];
   assign in3_o      = drive_q[0];
   assign busy_o     = (state_q == S_RUN) || (state_q == S_FINISH);
   assign done_o     = (state_q == S_FINISH);
   assign pass_o     = pass_q;
   assign table_o    = table_q;
   assign mismatch_o = mismatch_q;
   assign unstable_o = unstable_q;

endmodule
